// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   Framing controller for the UART transmit path. It runs on the TX baud
//   clock, so one CLK cycle is one bit time. It accepts a byte, pulses
//   ser_en to load the external serializer, and then drives the frame onto
//   TX_OUT: start bit, DATA_WIDTH data bits taken from ser_data (LSB first),
//   an optional parity bit, and one stop bit. A new byte offered during the
//   stop bit chains directly into the next frame with no idle gap.
//
// Ports
//   CLK        TX baud clock; all logic on the rising edge
//   RST        asynchronous active-low reset
//   P_DATA     parallel data, sampled on the accept cycle
//   Data_Valid transmit request; accepted only in IDLE or STOP
//   PAR_EN     1 = append a parity bit; sampled on the accept cycle
//   PAR_TYP    0 = even parity, 1 = odd parity; sampled on the accept cycle
//   ser_done   serializer idle, or presenting its last bit
//   ser_data   current data bit from the serializer
//   ser_en     serializer load strobe; high only in the accept cycle
//   TX_OUT     serial line, idle high
//   busy       high while a frame is in progress
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic   par_bit_q, par_bit_d;   // XOR of the accepted data word
    logic   par_en_q,  par_en_d;
    logic   par_typ_q, par_typ_d;
    logic   accept;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end

    // Next-state, frame-setup latches and the load strobe.
    always_comb begin
        state_d   = state_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        ser_en    = 1'b0;

        accept = Data_Valid && ((state_q == IDLE) || (state_q == STOP));

        if (accept) begin
            ser_en    = 1'b1;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            par_bit_d = ^P_DATA;
        end

        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = DATA;
            DATA:    if (ser_done) state_d = par_en_q ? PARITY : STOP;
            PARITY:  state_d = STOP;
            STOP:    state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line driver: decode of registered state plus the registered serializer
    // bit, so nothing from the input pins reaches TX_OUT combinationally.
    // The stored even parity is inverted here for odd parity; the line value
    // equals latching ^P_DATA / ~^P_DATA directly.
    always_comb begin
        case (state_q)
            IDLE:    TX_OUT = 1'b1;
            START:   TX_OUT = 1'b0;
            DATA:    TX_OUT = ser_data;
            PARITY:  TX_OUT = par_bit_q ^ par_typ_q;
            STOP:    TX_OUT = 1'b1;
            default: TX_OUT = 1'b1;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    localparam int unsigned DW = 8;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          ser_done;
    logic          ser_data;
    logic          ser_en;
    logic          TX_OUT;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_no = 0;

    typedef struct {
        logic bit_v;
        int   frame;
        int   idx;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Serializer model: loads on ser_en, shifts at the end of START, shows
    // bit i in DATA cycle i+1, done in the last data cycle or when idle.
    logic [DW-1:0] sh;
    int unsigned   cnt;
    logic          active;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh       <= '0;
            cnt      <= 0;
            active   <= 1'b0;
            ser_data <= 1'b0;
        end else if (ser_en) begin
            sh     <= P_DATA;
            cnt    <= 0;
            active <= 1'b1;
        end else if (active && cnt < DW) begin
            ser_data <= sh[0];
            sh       <= sh >> 1;
            cnt      <= cnt + 1;
        end else begin
            active <= 1'b0;
        end
    end

    assign ser_done = !active || (cnt == DW);

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected line bit per busy cycle; while idle the
    // line must be high and nothing may be pending.
    always @(negedge CLK) begin
        if (RST) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    check("busy_without_expected_bit", busy, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("tx_bit f%0d i%0d", e.frame, e.idx), TX_OUT, e.bit_v);
                end
            end else begin
                check("idle_tx_high", TX_OUT, 1'b1);
                check("idle_nothing_pending", (exp_q.size() != 0), 1'b0);
            end
        end
    end

    // Issue one request (called #1 after a rising edge); returns #1 after
    // the accept edge, i.e. inside the START cycle.
    task automatic send(input logic [DW-1:0] d, input logic pen,
                        input logic ptyp, input logic exp_par);
        logic [DW-1:0] dv;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        Data_Valid = 1'b1;
        #1;
        check("ser_en_on_accept", ser_en, 1'b1);
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        check("ser_en_after_accept", ser_en, 1'b0);
        frame_no++;
        dv = d;
        exp_q.push_back('{1'b0, frame_no, 0});
        for (int i = 0; i < DW; i++) exp_q.push_back('{dv[i], frame_no, i + 1});
        if (pen) exp_q.push_back('{exp_par, frame_no, DW + 1});
        exp_q.push_back('{1'b1, frame_no, DW + 2});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("frame_completes_in_budget", (n < 40), 1'b1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST        = 1'b0;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #12;
        check("reset_tx_high", TX_OUT, 1'b1);
        check("reset_busy_low", busy, 1'b0);
        check("reset_ser_en_low", ser_en, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("idle_busy_low", busy, 1'b0);
            check("idle_ser_en_low", ser_en, 1'b0);
        end
        @(posedge CLK);
        #1;

        // 0xA5 even parity: line 0,1,0,1,0,0,1,0,1,0,1
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        wait_idle();

        // 0x01 odd -> parity 0; inputs disturbed mid-frame
        send(8'h01, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        PAR_TYP = 1'b0;
        PAR_EN  = 1'b0;
        P_DATA  = 8'hFE;
        wait_idle();

        // 0x01 even -> parity 1
        send(8'h01, 1'b1, 1'b0, 1'b1);
        repeat (5) @(posedge CLK);
        #1;
        PAR_TYP = 1'b1;
        wait_idle();

        // 0xFF no parity: 10-cycle frame
        send(8'hFF, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Back-to-back: second request in the STOP cycle of the first
        send(8'h3C, 1'b1, 1'b0, 1'b0);
        repeat (10) @(posedge CLK);
        #1;
        check("b2b_in_stop_tx_high", TX_OUT, 1'b1);
        send(8'hC3, 1'b1, 1'b0, 1'b0);
        check("b2b_no_gap_busy", busy, 1'b1);
        check("b2b_second_start", TX_OUT, 1'b0);
        wait_idle();

        // Ignored request while busy
        send(8'h0F, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        P_DATA     = 8'h80;
        Data_Valid = 1'b1;
        #1;
        check("no_ser_en_while_busy", ser_en, 1'b0);
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        wait_idle();

        // Reset in the 4th DATA cycle of 0x5A
        send(8'h5A, 1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        exp_q.delete();
        check("midreset_tx_high", TX_OUT, 1'b1);
        check("midreset_busy_low", busy, 1'b0);
        check("midreset_ser_en_low", ser_en, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("post_reset_idle", busy, 1'b0);
        send(8'h5A, 1'b1, 1'b0, 1'b0);
        wait_idle();

        repeat (2) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
